// File: rtl/cram_loader_pkg.sv
// Shared types and default sizes for the CRAM configuration loader.
package cram_loader_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cram_readback_sipo.sv
// Collects bits leaving the CRAM chain tail into readback words, LSB first.
// A partial word is flushed zero-padded when the load completes.
module cram_readback_sipo
  import cram_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cap_en,
  input  logic                  cap_bit,
  input  logic                  flush,
  input  logic                  clr,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [CNT_W-1:0]      cap_cnt_q;
  logic [WORD_WIDTH-1:0] rxsr_q;
  logic [WORD_WIDTH-1:0] cap_word;
  logic                  word_full;

  // Word as it looks once this cycle's tail bit is written at the fill position.
  always_comb begin
    cap_word            = rxsr_q;
    cap_word[cap_cnt_q] = cap_bit;
    word_full           = (cap_cnt_q == CNT_W'(WORD_WIDTH - 1));
  end

  // Capture, emit a full or flushed word, or drop the partial word on clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cap_cnt_q <= '0;
      rxsr_q    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (clr) begin
        cap_cnt_q <= '0;
        rxsr_q    <= '0;
      end else if (cap_en) begin
        if (word_full || flush) begin
          rd_data   <= cap_word;
          rd_valid  <= 1'b1;
          cap_cnt_q <= '0;
          rxsr_q    <= '0;
        end else begin
          rxsr_q    <= cap_word;
          cap_cnt_q <= cap_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cram_loader.sv
// Serialises host configuration words LSB first onto the CRAM chain head and
// returns the bits leaving the chain tail as readback words.
module cram_loader
  import cram_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  chain_len,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  cfg_bit_out,
  output logic                  config_en,
  input  logic                  cfg_tail_in,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WCNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  n_q;
  logic [LEN_WIDTH-1:0]  bit_cnt_q;
  logic [WCNT_W-1:0]     word_cnt_q;
  logic [WORD_WIDTH-1:0] txsr_q;

  logic last_bit, last_in_word;
  logic load_tx, shift_tx, latch_n, flush;
  logic cfg_bit_d, done_d, err_d;

  // Next state and next output values; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    load_tx      = 1'b0;
    shift_tx     = 1'b0;
    latch_n      = 1'b0;
    flush        = 1'b0;
    cfg_bit_d    = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    last_bit     = (bit_cnt_q == n_q - LEN_WIDTH'(1));
    last_in_word = (word_cnt_q == WCNT_W'(WORD_WIDTH - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          if (chain_len == '0) begin
            err_d = 1'b1;
          end else begin
            latch_n = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (wr_valid && wr_ready) begin
          load_tx   = 1'b1;
          cfg_bit_d = wr_data[0];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = DONE;
          done_d  = 1'b1;
          flush   = 1'b1;
        end else if (last_in_word) begin
          state_d = LOAD;
        end else begin
          shift_tx  = 1'b1;
          cfg_bit_d = txsr_q[0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      load_tx   = 1'b0;
      shift_tx  = 1'b0;
      latch_n   = 1'b0;
      flush     = 1'b0;
      cfg_bit_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ready    <= 1'b0;
      config_en   <= 1'b0;
      busy        <= 1'b0;
      cfg_bit_out <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wr_ready    <= (state_d == LOAD);
      config_en   <= (state_d == SHIFT);
      busy        <= (state_d != IDLE);
      cfg_bit_out <= cfg_bit_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  // Chain length latch and bit/word counters; each SHIFT cycle is one chain shift.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_q        <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      if (latch_n) begin
        n_q       <= chain_len;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT && !abort) begin
        bit_cnt_q <= bit_cnt_q + LEN_WIDTH'(1);
      end
      if (load_tx) begin
        word_cnt_q <= '0;
      end else if (state_q == SHIFT && !abort) begin
        word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end
    end
  end

  // TX shift register holds the bits still to be presented; bit 0 goes out on the handshake.
  always_ff @(posedge clk) begin
    if (load_tx)       txsr_q <= {1'b0, wr_data[WORD_WIDTH-1:1]};
    else if (shift_tx) txsr_q <= {1'b0, txsr_q[WORD_WIDTH-1:1]};
  end

  cram_readback_sipo #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_readback (
    .clk      (clk),
    .nrst     (nrst),
    .cap_en   (config_en),
    .cap_bit  (cfg_tail_in),
    .flush    (flush),
    .clr      (abort),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_cram_loader.sv
// Randomised bench for cram_loader with a transaction-level reference model.
module tb_cram_loader;

  logic        clk = 1'b0;
  logic        nrst, start, abort, wr_valid, wr_ready, cfg_bit_out, config_en;
  logic        cfg_tail_in, rd_valid, busy, done, err;
  logic [19:0] chain_len;
  logic [31:0] wr_data, rd_data;

  always #5 clk = ~clk;

  cram_loader #(.WORD_WIDTH(32), .LEN_WIDTH(20)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .chain_len(chain_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .cfg_bit_out(cfg_bit_out), .config_en(config_en), .cfg_tail_in(cfg_tail_in),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
  );

  // 64-bit model of the configuration chain: shifts in at the head, tail is bit 0.
  logic [63:0] chain, preload_val;
  logic        preload_req;
  assign cfg_tail_in = chain[0];
  always @(posedge clk) begin
    if (preload_req)    chain <= preload_val;
    else if (config_en) chain <= {cfg_bit_out, chain[63:1]};
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ld_words[$];
  int          ld_stalls[$];
  logic [63:0] ld_preload;
  int          ld_busy_start;
  logic [31:0] last_rd[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload(input logic [63:0] v);
    preload_val = v;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  // One complete load: model expectations, drive, observe, compare.
  task automatic run_load(input string nm, input int n);
    bit          exp_en[$], exp_rv[$], exp_tx[$], obs_en[$], obs_rv[$], obs_tx[$];
    logic [31:0] exp_rd[$], obs_rd[$];
    logic [31:0] acc, ow, ew;
    int          nw, nb, exp_done, cnt, done_c, ndone, nerr, widx, stall_left, mis_en, mis_rv, m;
    bit          fin, hs, tbit;
    nw = (n + 31) / 32;
    exp_en.push_back(1'b0);
    for (int k = 0; k < nw; k++) begin
      nb = (n - 32 * k < 32) ? n - 32 * k : 32;
      for (int s = 0; s <= ld_stalls[k]; s++) exp_en.push_back(1'b0);
      for (int b = 0; b < nb; b++) begin
        exp_en.push_back(1'b1);
        exp_tx.push_back(ld_words[k][b]);
      end
    end
    exp_done = exp_en.size();
    exp_en.push_back(1'b0);
    for (int t = 0; t < exp_en.size(); t++) exp_rv.push_back(1'b0);
    cnt = 0;
    for (int t = 0; t < exp_en.size(); t++) begin
      if (exp_en[t]) begin
        cnt++;
        if (cnt % 32 == 0 || cnt == n) exp_rv[t+1] = 1'b1;
      end
    end
    acc = '0;
    for (int i = 0; i < n; i++) begin
      tbit = (i < 64) ? ld_preload[i] : exp_tx[i-64];
      acc[i%32] = tbit;
      if (i % 32 == 31 || i == n - 1) begin
        exp_rd.push_back(acc);
        acc = '0;
      end
    end

    do_preload(ld_preload);
    start = 1'b1; chain_len = n[19:0]; wr_valid = 1'b0; wr_data = $urandom;
    obs_en.push_back(config_en);
    obs_rv.push_back(rd_valid);
    tick();
    start = 1'b0;
    done_c = -1; ndone = 0; nerr = 0; widx = 0; stall_left = ld_stalls[0]; fin = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      if (done_c >= 0 && c == done_c + 1) begin
        check({nm, "_busy_after_done"}, 64'(busy), 64'd0);
        fin = 1'b1;
        break;
      end
      obs_en.push_back(config_en);
      obs_rv.push_back(rd_valid);
      if (config_en) obs_tx.push_back(cfg_bit_out);
      if (rd_valid) obs_rd.push_back(rd_data);
      if (done) begin ndone++; done_c = c; end
      if (err) nerr++;
      if (c == ld_busy_start) begin start = 1'b1; chain_len = 20'd3; end
      else start = 1'b0;
      hs = 1'b0;
      if (widx < nw && stall_left > 0 && wr_ready) begin
        wr_valid = 1'b0; wr_data = $urandom; stall_left--;
      end else if (widx < nw && stall_left == 0) begin
        wr_valid = 1'b1; wr_data = ld_words[widx]; hs = wr_ready;
      end else begin
        wr_valid = 1'b0; wr_data = $urandom;
      end
      tick();
      if (hs) begin
        widx++;
        stall_left = (widx < nw) ? ld_stalls[widx] : 0;
      end
    end
    start = 1'b0; wr_valid = 1'b0;
    check({nm, "_finished"}, 64'(fin), 64'd1);
    check({nm, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    check({nm, "_done_count"}, 64'(ndone), 64'd1);
    check({nm, "_err_count"}, 64'(nerr), 64'd0);
    check({nm, "_trace_len"}, 64'(obs_en.size()), 64'(exp_en.size()));
    m = (obs_en.size() < exp_en.size()) ? obs_en.size() : exp_en.size();
    mis_en = 0; mis_rv = 0;
    for (int t = 0; t < m; t++) begin
      if (obs_en[t] !== exp_en[t]) mis_en++;
      if (obs_rv[t] !== exp_rv[t]) mis_rv++;
    end
    check({nm, "_config_en_trace_bad_cycles"}, 64'(mis_en), 64'd0);
    check({nm, "_rd_valid_trace_bad_cycles"}, 64'(mis_rv), 64'd0);
    check({nm, "_tx_bits"}, 64'(obs_tx.size()), 64'(n));
    for (int k = 0; k < nw; k++) begin
      ow = '0; ew = '0;
      for (int b = 0; b < 32; b++) begin
        if (32 * k + b < n) begin
          ew[b] = exp_tx[32*k+b];
          if (32 * k + b < obs_tx.size()) ow[b] = obs_tx[32*k+b];
        end
      end
      check($sformatf("%s_tx_word%0d", nm, k), 64'(ow), 64'(ew));
    end
    check({nm, "_rd_count"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size(); k++) begin
      ow = (k < obs_rd.size()) ? obs_rd[k] : 32'h0;
      check($sformatf("%s_rd_word%0d", nm, k), 64'(ow), 64'(exp_rd[k]));
    end
    last_rd = obs_rd;
  endtask

  // Start an N=32 load and stop just inside the cycle presenting shift number 'at'.
  task automatic run_to_shift(input string nm, input logic [31:0] w, input int at);
    int seen;
    bit hit;
    do_preload({$urandom, $urandom});
    start = 1'b1; chain_len = 20'd32; wr_valid = 1'b0;
    tick();
    start = 1'b0; wr_valid = 1'b1; wr_data = w;
    seen = 0; hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (config_en) begin
        seen++;
        wr_valid = 1'b0;
      end
      if (seen == at) begin hit = 1'b1; break; end
      tick();
    end
    check({nm, "_reached_shift"}, 64'(hit), 64'd1);
  endtask

  initial begin
    int nd, nrv, nen, nrdy, nbusy, n;
    nrst = 1'b0; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0;
    chain_len = '0; preload_req = 1'b0; preload_val = '0; ld_busy_start = -1;
    ld_preload = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_config_en", 64'(config_en), 64'd0);
    check("rst_cfg_bit_out", 64'(cfg_bit_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    nrst = 1'b1;
    tick();

    // zero-length start
    start = 1'b1; chain_len = 20'd0;
    tick();
    start = 1'b0;
    check("zero_len_err", 64'(err), 64'd1);
    check("zero_len_busy", 64'(busy), 64'd0);
    check("zero_len_wr_ready", 64'(wr_ready), 64'd0);
    tick();
    check("zero_len_err_pulse", 64'(err), 64'd0);
    check("zero_len_busy_after", 64'(busy), 64'd0);

    ld_words = {32'h0000_00A5}; ld_stalls = {0}; ld_preload = {$urandom, $urandom};
    run_load("n8_a5", 8);

    ld_words = {32'hFFFF_0000, 32'h0000_00C3}; ld_stalls = {0, 0};
    ld_preload = {$urandom, $urandom};
    run_load("n40_stream", 40);

    ld_words = {$urandom, $urandom}; ld_stalls = {0, 0};
    ld_preload = 64'hDEAD_BEEF_0123_4567;
    run_load("n64_readback", 64);
    check("n64_rb_word0_const", 64'(last_rd[0]), 64'h0123_4567);
    check("n64_rb_word1_const", 64'(last_rd[1]), 64'hDEAD_BEEF);

    ld_words = {32'hFFFF_0000, 32'h0000_00C3}; ld_stalls = {0, 5};
    ld_preload = {$urandom, $urandom}; ld_busy_start = 10;
    run_load("n40_stall_busy_start", 40);
    ld_busy_start = -1;

    // abort at shift 10
    run_to_shift("abort", $urandom, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_config_en", 64'(config_en), 64'd0);
    check("abort_wr_ready", 64'(wr_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    nd = 0; nrv = 0; nen = 0; nrdy = 0; nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) nd++;
      if (rd_valid) nrv++;
      if (config_en) nen++;
      if (wr_ready) nrdy++;
      if (busy) nbusy++;
      tick();
    end
    check("abort_no_done", 64'(nd), 64'd0);
    check("abort_no_rd_valid", 64'(nrv), 64'd0);
    check("abort_no_config_en", 64'(nen), 64'd0);
    check("abort_idle_no_ready", 64'(nrdy), 64'd0);
    check("abort_idle_not_busy", 64'(nbusy), 64'd0);

    // reset in the middle of SHIFT
    run_to_shift("mid_reset", 32'hFFFF_FFFF, 10);
    check("mid_reset_pre_bit", 64'(cfg_bit_out), 64'd1);
    check("mid_reset_pre_busy", 64'(busy), 64'd1);
    nrst = 1'b0;
    #2;
    check("mid_reset_outputs",
          64'({wr_ready, cfg_bit_out, config_en, rd_valid, busy, done, err, rd_data}), 64'd0);
    tick();
    tick();
    nrst = 1'b1;
    tick();
    check("post_reset_outputs",
          64'({wr_ready, cfg_bit_out, config_en, rd_valid, busy, done, err, rd_data}), 64'd0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 120);
      ld_words.delete();
      ld_stalls.delete();
      for (int k = 0; k < (n + 31) / 32; k++) begin
        ld_words.push_back($urandom);
        ld_stalls.push_back($urandom_range(0, 3));
      end
      ld_preload = {$urandom, $urandom};
      run_load($sformatf("rand%0d_n%0d", r, n), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
